// File: rtl/hamming_secded_pipe.sv
// hamming_secded_pipe: two-stage pipelined SECDED Hamming decoder with
// valid/ready flow control, a sticky double-error flag and optional
// saturating error counters (built only when HAMMING_ERR_COUNT_EN is defined).
//
// Codeword layout: bit i (0..CW_W-2) is Hamming position i+1, check bits sit
// at power-of-two positions, and bit CW_W-1 is overall even parity.
// Stage 1 holds the raw codeword with its syndrome and overall parity.
// Stage 2 holds the corrected payload, error code and syndrome.

module hamming_secded_pipe #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16,
  localparam int P_W   = (DATA_W <= 4)  ? 3 :
                         (DATA_W <= 11) ? 4 :
                         (DATA_W <= 26) ? 5 : 6,
  localparam int CW_W  = DATA_W + P_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_cw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_err,
  output logic [P_W-1:0]    out_syndrome,
  output logic              dbl_flag,
  input  logic              flag_clr,
  output logic [CNT_W-1:0]  cnt_single,
  output logic [CNT_W-1:0]  cnt_double,
  input  logic              cnt_clr
);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_OVERALL = 2'b01;
  localparam logic [1:0] ERR_SINGLE  = 2'b10;
  localparam logic [1:0] ERR_DOUBLE  = 2'b11;

  // Highest Hamming position that physically exists in the codeword.
  localparam int MAX_POS = CW_W - 1;

  // XOR of the positions of every set bit below the overall-parity bit.
  function automatic logic [P_W-1:0] calc_syndrome(input logic [CW_W-1:0] cw);
    logic [P_W-1:0] s;
    s = '0;
    for (int i = 0; i < CW_W - 1; i++) begin
      if (cw[i]) s = s ^ P_W'(i + 1);
    end
    return s;
  endfunction

  // Gather payload bits from the non-power-of-two positions, lowest first.
  function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int pos = 1; pos < CW_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[j] = cw[pos-1];
        j++;
      end
    end
    return d;
  endfunction

  logic              s1_valid_q, s1_valid_d;
  logic [CW_W-1:0]   s1_cw_q, s1_cw_d;
  logic [P_W-1:0]    s1_syn_q, s1_syn_d;
  logic              s1_op_q, s1_op_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        out_err_q, out_err_d;
  logic [P_W-1:0]    out_syn_q, out_syn_d;

  logic              dbl_flag_q, dbl_flag_d;

  logic              s1_adv;
  logic              s2_adv;
  logic              deliver;

  logic [1:0]        class_err;
  logic [CW_W-1:0]   flip_mask;
  logic              syn_in_range;
  logic [DATA_W-1:0] corr_data;

  // Each stage may load when the stage after it is empty or being drained.
  always_comb begin
    s2_adv  = !out_valid_q || out_ready;
    s1_adv  = !s1_valid_q || s2_adv;
    deliver = out_valid_q && out_ready;
  end

  assign in_ready = s1_adv;

  // Stage 1 captures the codeword together with its syndrome and overall parity.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_cw_d    = s1_cw_q;
    s1_syn_d   = s1_syn_q;
    s1_op_d    = s1_op_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_cw_d  = in_cw;
        s1_syn_d = calc_syndrome(in_cw);
        s1_op_d  = ^in_cw;
      end
    end
  end

  // Classify the stage 1 word; only a syndrome naming a real bit is correctable.
  always_comb begin
    class_err    = ERR_NONE;
    flip_mask    = '0;
    syn_in_range = (32'(s1_syn_q) <= MAX_POS);
    if (s1_syn_q == '0) begin
      class_err = s1_op_q ? ERR_OVERALL : ERR_NONE;
    end else if (s1_op_q && syn_in_range) begin
      class_err = ERR_SINGLE;
      flip_mask[s1_syn_q - 1'b1] = 1'b1;
    end else begin
      class_err = ERR_DOUBLE;
    end
    corr_data = extract_data(s1_cw_q ^ flip_mask);
  end

  // Stage 2 only reloads when it can advance, so outputs hold while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    out_syn_d   = out_syn_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = corr_data;
        out_err_d  = class_err;
        out_syn_d  = s1_syn_q;
      end
    end
  end

  // Pipeline registers; reset empties both stages and drops in-flight words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_cw_q     <= '0;
      s1_syn_q    <= '0;
      s1_op_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= ERR_NONE;
      out_syn_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_cw_q     <= s1_cw_d;
      s1_syn_q    <= s1_syn_d;
      s1_op_q     <= s1_op_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      out_syn_q   <= out_syn_d;
    end
  end

  // Sticky double-error flag; a delivered uncorrectable word beats a clear.
  always_comb begin
    dbl_flag_d = dbl_flag_q;
    if (flag_clr) dbl_flag_d = 1'b0;
    if (deliver && (out_err_q == ERR_DOUBLE)) dbl_flag_d = 1'b1;
  end

  // Flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dbl_flag_q <= 1'b0;
    else        dbl_flag_q <= dbl_flag_d;
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_err      = out_err_q;
  assign out_syndrome = out_syn_q;
  assign dbl_flag     = dbl_flag_q;

`ifdef HAMMING_ERR_COUNT_EN
  logic [CNT_W-1:0] cnt_single_q, cnt_single_d;
  logic [CNT_W-1:0] cnt_double_q, cnt_double_d;

  // Saturating delivery counters; a clear overrides any increment that cycle.
  always_comb begin
    cnt_single_d = cnt_single_q;
    cnt_double_d = cnt_double_q;
    if (deliver) begin
      if ((out_err_q == ERR_OVERALL || out_err_q == ERR_SINGLE) && (cnt_single_q != '1))
        cnt_single_d = cnt_single_q + 1'b1;
      if ((out_err_q == ERR_DOUBLE) && (cnt_double_q != '1))
        cnt_double_d = cnt_double_q + 1'b1;
    end
    if (cnt_clr) begin
      cnt_single_d = '0;
      cnt_double_d = '0;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_single_q <= '0;
      cnt_double_q <= '0;
    end else begin
      cnt_single_q <= cnt_single_d;
      cnt_double_q <= cnt_double_d;
    end
  end

  assign cnt_single = cnt_single_q;
  assign cnt_double = cnt_double_q;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign cnt_single     = '0;
  assign cnt_double     = '0;
`endif

endmodule
